if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM address.
- Captures the returned 32-bit instruction into an IF/ID register for the decoder.
- Accepts branch (beq/bne) and jump (j) redirects from later stages, and a stall from hazard logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 32, number of valid instruction words; used for the range check.
- NOP_INST, 32'h0000_0000, instruction placed in IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents this cycle.
- br_taken  in  1  branch resolved taken this cycle.
- br_base  in  32  PC+4 of the branch instruction.
- br_imm  in  16  branch immediate, signed word offset.
- jmp  in  1  jump resolved this cycle.
- jmp_base  in  32  PC+4 of the jump instruction (supplies upper 4 bits).
- jmp_index  in  26  jump target index field.
- imem_inst  in  32  instruction returned combinationally by the instruction ROM for imem_addr.
- imem_addr  out  32  current PC, byte address to the instruction ROM.
- id_inst  out  32  IF/ID instruction.
- id_pc4  out  32  IF/ID PC+4 of the held instruction.
- id_valid  out  1  IF/ID holds a real instruction.
- fetch_fault  out  1  sticky flag: PC left the instruction range or was misaligned.

Behaviour:
- Reset (synchronous, active-high, wins over all inputs):
  - PC <= RESET_PC, id_inst <= NOP_INST, id_pc4 <= 0, id_valid <= 0, fetch_fault <= 0.
- imem_addr = PC; it is a register output with no combinational path from inputs.
- Target arithmetic, 32-bit modulo 2^32 (PC+4 at 0xFFFF_FFFC wraps to 0):
  - br_target = br_base + ({{14{br_imm[15]}}, br_imm, 2'b00}).
  - jmp_target = {jmp_base[31:28], jmp_index, 2'b00}.
- Next-PC priority, evaluated each non-reset cycle:
  1. jmp=1: PC <= jmp_target. id_inst <= NOP_INST, id_valid <= 0 (flush). id_pc4 is don't-care but is written 0.
  2. else br_taken=1: PC <= br_target, same flush.
  3. else stall=1: PC, id_inst, id_pc4 and id_valid all hold.
  4. else: PC <= PC+4, id_inst <= imem_inst, id_pc4 <= PC+4, id_valid <= 1.
- Simultaneous events:
  - jmp and br_taken together: jump wins; br_taken is ignored.
  - A redirect overrides stall: the redirect is applied and IF/ID is flushed even while stall=1.
- Latency:
  - An instruction at PC appears on id_inst one clock after PC is presented.
  - After a redirect, the target instruction appears on id_inst two clocks after the redirect cycle.
- Fault check:
  - fetch_fault sets when a PC with PC[1:0]!=0 or PC[31:2] >= IMEM_WORDS is presented on imem_addr.
  - Once set, it stays set until reset.
  - Fetching continues normally; the flag is advisory only.
  - An id_inst captured from a faulting PC is still marked valid.
- Reset asserted mid-stall or mid-redirect takes effect at that edge; no pending redirect survives reset.

Decomposition:
- Shared package holds:
  - Opcode constants (OP_J=6'b000010, OP_BEQ=6'b000100, OP_BNE=6'b000101).
  - The NOP_INST constant.
  - The PC width constant (32).
- One natural sub-module: if_next_pc, the purely combinational target and priority selection.
- The PC, IF/ID and fault registers stay in the top.

Test Plan:
- Reset then 4 free-running clocks:
  - imem_addr = 0x00, 0x04, 0x08, 0x0C.
  - id_pc4 lags by one clock with values 0x04, 0x08, 0x0C.
  - id_valid becomes 1 from the second clock.
- Branch: br_taken=1, br_base=0x2C, br_imm=16'h0002 -> next imem_addr=0x34, id_valid=0 for one cycle, then id_pc4=0x38.
- Backward branch: br_base=0x10, br_imm=16'hFFFC -> imem_addr=0x00.
- Jump: jmp=1, jmp_base=0x50, jmp_index=26'h00000F -> imem_addr=0x3C.
  - Raise br_taken=1 in the same cycle with br_target 0x34; the result is still 0x3C.
- Stall:
  - Hold stall=1 for 3 clocks at PC=0x14: imem_addr, id_inst and id_pc4 are unchanged.
  - Drive jmp=1 during the stall: PC updates to the jump target and id_valid=0.
- Range and wrap:
  - Jump with jmp_index=26'h000020 -> imem_addr=0x80, and fetch_fault=1 on the next edge.
  - fetch_fault stays 1 until reset; the reset edge clears all outputs to their reset values.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: datapath width,
// the flush/reset NOP encoding, and the control-flow opcodes that cause redirects.
package if_fetch_stage_pkg;

    localparam int PC_W = 32;

    // sll $0,$0,0 encodes as all zeros.
    localparam logic [PC_W-1:0] NOP_INST_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage signal bundle. Redirect/stall and ROM data flow into the stage;
// ROM address and IF/ID contents flow out. No valid/ready handshake: every
// input is sampled at each rising clock edge.
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_base;
    logic [15:0]     br_imm;
    logic            jmp;
    logic [PC_W-1:0] jmp_base;
    logic [25:0]     jmp_index;
    logic [PC_W-1:0] imem_inst;
    logic [PC_W-1:0] imem_addr;
    logic [PC_W-1:0] id_inst;
    logic [PC_W-1:0] id_pc4;
    logic            id_valid;
    logic            fetch_fault;

    modport master (
        output stall, br_taken, br_base, br_imm, jmp, jmp_base, jmp_index, imem_inst,
        input  imem_addr, id_inst, id_pc4, id_valid, fetch_fault
    );

    modport slave (
        input  stall, br_taken, br_base, br_imm, jmp, jmp_base, jmp_index, imem_inst,
        output imem_addr, id_inst, id_pc4, id_valid, fetch_fault
    );

endinterface

// File: rtl/if_fetch_stage_next_pc.sv
// Combinational next-PC selection: jump over branch over stall over sequential fetch.
// Also reports whether IF/ID should flush or capture this cycle.
module if_next_pc
    import if_fetch_stage_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_base_i,
    input  logic [15:0]     br_imm_i,
    input  logic            jmp_i,
    input  logic [3:0]      jmp_base_hi_i,
    input  logic [25:0]     jmp_index_i,
    output logic [PC_W-1:0] pc_d_o,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic            flush_o,
    output logic            advance_o
);

    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] jmp_target;

    assign pc_plus4_o = pc_i + 32'd4;
    assign br_target  = br_base_i + {{14{br_imm_i[15]}}, br_imm_i, 2'b00};
    assign jmp_target = {jmp_base_hi_i, jmp_index_i, 2'b00};

    always_comb begin
        pc_d_o    = pc_i;
        flush_o   = 1'b0;
        advance_o = 1'b0;
        // Redirects take precedence over stall so a resolved branch is never lost.
        if (jmp_i) begin
            pc_d_o  = jmp_target;
            flush_o = 1'b1;
        end else if (br_taken_i) begin
            pc_d_o  = br_target;
            flush_o = 1'b1;
        end else if (!stall_i) begin
            pc_d_o    = pc_plus4_o;
            advance_o = 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, and registers
// the returned instruction into IF/ID. Raises a sticky advisory fault on bad PCs.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              IMEM_WORDS = 32,
    parameter logic [PC_W-1:0] NOP_INST   = NOP_INST_DEF
) (
    input logic           clk,
    input logic           reset,
    if_fetch_stage_if.slave fif
);

    logic [PC_W-1:0] pc_q,    pc_d;
    logic [PC_W-1:0] inst_q,  inst_d;
    logic [PC_W-1:0] pc4_q,   pc4_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic [PC_W-1:0] pc_plus4;
    logic            flush;
    logic            advance;
    logic            pc_bad;

    if_next_pc u_next_pc (
        .pc_i          (pc_q),
        .stall_i       (fif.stall),
        .br_taken_i    (fif.br_taken),
        .br_base_i     (fif.br_base),
        .br_imm_i      (fif.br_imm),
        .jmp_i         (fif.jmp),
        .jmp_base_hi_i (fif.jmp_base[31:28]),
        .jmp_index_i   (fif.jmp_index),
        .pc_d_o        (pc_d),
        .pc_plus4_o    (pc_plus4),
        .flush_o       (flush),
        .advance_o     (advance)
    );

    // The check looks at the PC currently on the ROM bus, so a bad target flags one edge later.
    assign pc_bad = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS));

    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q | pc_bad;
        if (flush) begin
            inst_d  = NOP_INST;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (advance) begin
            inst_d  = fif.imem_inst;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign fif.imem_addr   = pc_q;
    assign fif.id_inst     = inst_q;
    assign fif.id_pc4      = pc4_q;
    assign fif.id_valid    = valid_q;
    assign fif.fetch_fault = fault_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, branches, jumps,
// stall with redirect, range fault, and reset recovery.
module tb_if_fetch_stage;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    if_fetch_stage_if fif ();

    if_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    // ROM model: instruction word tags its own address so captures are traceable.
    assign fif.imem_inst = 32'hC000_0000 | fif.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fif.stall     = 1'b0;
        fif.br_taken  = 1'b0;
        fif.br_base   = '0;
        fif.br_imm    = '0;
        fif.jmp       = 1'b0;
        fif.jmp_base  = '0;
        fif.jmp_index = '0;
    endtask

    task automatic check_if(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic [31:0] pc4, input logic valid);
        check({tag, ".addr"},  fif.imem_addr, pc);
        check({tag, ".inst"},  fif.id_inst,   inst);
        check({tag, ".pc4"},   fif.id_pc4,    pc4);
        check({tag, ".valid"}, {31'd0, fif.id_valid}, {31'd0, valid});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_if("reset", 32'h00, 32'h0, 32'h0, 1'b0);
        check("reset.fault", {31'd0, fif.fetch_fault}, 32'd0);
        reset = 1'b0;

        // Sequential fetch from 0.
        tick(); check_if("seq1", 32'h04, 32'hC000_0000, 32'h04, 1'b1);
        tick(); check_if("seq2", 32'h08, 32'hC000_0004, 32'h08, 1'b1);
        tick(); check_if("seq3", 32'h0C, 32'hC000_0008, 32'h0C, 1'b1);
        tick(); check_if("seq4", 32'h10, 32'hC000_000C, 32'h10, 1'b1);
        tick(); check_if("seq5", 32'h14, 32'hC000_0010, 32'h14, 1'b1);

        // Stall at PC=0x14 for three clocks.
        fif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_if("stall", 32'h14, 32'hC000_0010, 32'h14, 1'b1);
        end

        // Jump and branch together during stall: jump wins, IF/ID flushes.
        fif.jmp       = 1'b1;
        fif.jmp_base  = 32'h50;
        fif.jmp_index = 26'h00000F;
        fif.br_taken  = 1'b1;
        fif.br_base   = 32'h2C;
        fif.br_imm    = 16'h0002;
        tick(); check_if("jmp_stall", 32'h3C, 32'h0, 32'h0, 1'b0);
        idle_inputs();
        tick(); check_if("jmp_after", 32'h40, 32'hC000_003C, 32'h40, 1'b1);

        // Forward branch.
        fif.br_taken = 1'b1;
        fif.br_base  = 32'h2C;
        fif.br_imm   = 16'h0002;
        tick(); check_if("br_fwd", 32'h34, 32'h0, 32'h0, 1'b0);
        idle_inputs();
        tick(); check_if("br_fwd_after", 32'h38, 32'hC000_0034, 32'h38, 1'b1);

        // Backward branch to 0.
        fif.br_taken = 1'b1;
        fif.br_base  = 32'h10;
        fif.br_imm   = 16'hFFFC;
        tick(); check_if("br_back", 32'h00, 32'h0, 32'h0, 1'b0);
        idle_inputs();
        tick(); check_if("br_back_after", 32'h04, 32'hC000_0000, 32'h04, 1'b1);
        check("fault_clear", {31'd0, fif.fetch_fault}, 32'd0);

        // Jump out of range: fault appears one edge after 0x80 is presented.
        fif.jmp       = 1'b1;
        fif.jmp_base  = 32'h0;
        fif.jmp_index = 26'h000020;
        tick(); check_if("jmp_oob", 32'h80, 32'h0, 32'h0, 1'b0);
        check("fault_pre", {31'd0, fif.fetch_fault}, 32'd0);
        idle_inputs();
        tick(); check_if("oob_fetch", 32'h84, 32'hC000_0080, 32'h84, 1'b1);
        check("fault_set", {31'd0, fif.fetch_fault}, 32'd1);

        // Back in range: fault remains sticky.
        fif.br_taken = 1'b1;
        fif.br_base  = 32'h8;
        fif.br_imm   = 16'h0000;
        tick(); check_if("br_inrange", 32'h08, 32'h0, 32'h0, 1'b0);
        check("fault_sticky", {31'd0, fif.fetch_fault}, 32'd1);
        idle_inputs();
        tick();
        check("fault_sticky2", {31'd0, fif.fetch_fault}, 32'd1);

        // Reset with a redirect pending: reset wins.
        reset         = 1'b1;
        fif.jmp       = 1'b1;
        fif.jmp_base  = 32'h0;
        fif.jmp_index = 26'h000005;
        tick(); check_if("reset2", 32'h00, 32'h0, 32'h0, 1'b0);
        check("reset2.fault", {31'd0, fif.fetch_fault}, 32'd0);
        idle_inputs();
        reset = 1'b0;
        tick(); check_if("post_reset", 32'h04, 32'hC000_0000, 32'h04, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
